// File: rtl/riscv_dmem_resp_if.sv
// -----------------------------------------------------------------------------
// riscv_dmem_resp_if
// EX-stage data-memory bus between the core (master) and a memory responder
// (slave). One word access per cycle.
//   dmem_en    : access request this cycle
//   dmem_we    : 1 = store, 0 = load
//   dmem_addr  : byte address, bits [1:0] ignored
//   dmem_wdata : store data
//   dmem_rdata : load data, combinational from the address
//   dmem_err   : registered one-cycle pulse after an unmapped access
// -----------------------------------------------------------------------------
interface riscv_dmem_resp_if;
  logic        dmem_en;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  modport master (
    output dmem_en, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_err
  );

  modport slave (
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_err
  );
endinterface

// File: rtl/riscv_dmem_resp.sv
// -----------------------------------------------------------------------------
// riscv_dmem_resp
// Data-memory responder: local word RAM plus a memory-mapped sensor window
// (sample FIFO, saturating overflow counter, anomaly-alert register).
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus            : DMEM slave (en/we/addr/wdata in, rdata/err out)
//   sensor_valid   : sensor sample offered
//   sensor_data    : sensor sample
//   sensor_ready   : FIFO not full
//   anomaly_alert  : alert register non-zero
//   alert_code     : alert register value
// Map: RAM at word < RAM_WORDS (addr[31:28] = 0); 0x1000_0000 DATA (read pops),
//      0x1000_0004 STATUS, 0x1000_0008 ALERT, 0x1000_000C OVF (write clears).
// -----------------------------------------------------------------------------
module riscv_dmem_resp #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVF_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  riscv_dmem_resp_if.slave        bus,
  input  logic                    sensor_valid,
  input  logic [31:0]             sensor_data,
  output logic                    sensor_ready,
  output logic                    anomaly_alert,
  output logic [7:0]              alert_code
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  // Address decode
  logic [29:0]       word;
  logic              sel_ram, sel_sensor, sel_data, sel_status, sel_alert, sel_ovf;
  logic              mapped, rd, wr;
  logic [RAM_AW-1:0] ram_idx;

  assign word       = bus.dmem_addr[31:2];
  assign sel_ram    = (bus.dmem_addr[31:28] == 4'h0) && (word < 30'(RAM_WORDS));
  assign sel_sensor = (bus.dmem_addr[31:4] == 28'h100_0000);
  assign sel_data   = sel_sensor && (bus.dmem_addr[3:2] == 2'd0);
  assign sel_status = sel_sensor && (bus.dmem_addr[3:2] == 2'd1);
  assign sel_alert  = sel_sensor && (bus.dmem_addr[3:2] == 2'd2);
  assign sel_ovf    = sel_sensor && (bus.dmem_addr[3:2] == 2'd3);
  assign mapped     = sel_ram || sel_sensor;
  assign rd         = bus.dmem_en && !bus.dmem_we;
  assign wr         = bus.dmem_en && bus.dmem_we;
  assign ram_idx    = bus.dmem_addr[RAM_AW+1:2];

  // Byte offset is ignored: accesses are word-only
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.dmem_addr[1:0];

  // Storage (not reset)
  logic [31:0] ram      [RAM_WORDS];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  // Control state
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [OVF_W-1:0] ovf;
  logic [7:0]       alert_reg;
  logic             err_q;

  logic full, empty, push, pop, ovf_evt, ovf_clr;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = sensor_valid && !full;       // full blocks push even with a pop
  assign pop     = rd && sel_data && !empty;
  assign ovf_evt = sensor_valid && full;
  assign ovf_clr = wr && sel_ovf;

  // Combinational load data
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_ram) begin
        rdata = ram[ram_idx];
      end else if (sel_data) begin
        rdata = empty ? 32'h0 : fifo_mem[rd_ptr];
      end else if (sel_status) begin
        rdata = {16'(ovf), 8'(count), 6'b0, full, empty};
      end else if (sel_alert) begin
        rdata = {24'b0, alert_reg};
      end else if (sel_ovf) begin
        rdata = 32'(ovf);
      end
    end
  end

  // RAM and FIFO payload writes; reset suppresses coincident writes
  always_ff @(posedge clk) begin
    if (rst_n && wr && sel_ram) begin
      ram[ram_idx] <= bus.dmem_wdata;
    end
    if (rst_n && push) begin
      fifo_mem[wr_ptr] <= sensor_data;
    end
  end

  // Pointers, count, overflow counter, alert and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf       <= '0;
      alert_reg <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A clear racing an overflow still records that overflow
      if (ovf_clr) begin
        ovf <= ovf_evt ? OVF_W'(1) : '0;
      end else if (ovf_evt && (ovf != OVF_MAX)) begin
        ovf <= ovf + OVF_W'(1);
      end

      if (wr && sel_alert) alert_reg <= bus.dmem_wdata[7:0];

      err_q <= bus.dmem_en && !mapped;
    end
  end

  assign bus.dmem_rdata = rdata;
  assign bus.dmem_err   = err_q;
  assign sensor_ready   = !full;
  assign anomaly_alert  = |alert_reg;
  assign alert_code     = alert_reg;

endmodule

// File: doc/riscv_dmem_resp.md
Name: riscv_dmem_resp

Overview:
Data-memory responder on the EX-stage DMEM interface. It serves word loads and stores to a local RAM and to a small memory-mapped sensor window. The sensor window holds an ingress FIFO of ECG/biosignal samples, an overflow counter and an anomaly-alert register. It sits beside the 3-stage core top and answers `dmem_en`/`dmem_we`/`dmem_addr`/`dmem_wdata` with same-cycle `dmem_rdata`, so the WB stage can select it exactly as it does now.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; power of two, at least 4.
- FIFO_DEPTH, 8, number of sensor FIFO entries; power of two, 2 to 128.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- dmem_en, input, 1, access request this cycle.
- dmem_we, input, 1, 1 = store, 0 = load; only meaningful when dmem_en = 1.
- dmem_addr, input, 32, byte address; bits [1:0] ignored (word accesses only).
- dmem_wdata, input, 32, store data.
- dmem_rdata, output, 32, load data, combinational from the address.
- sensor_valid, input, 1, sensor sample offered.
- sensor_data, input, 32, sensor sample.
- sensor_ready, output, 1, equals !full.
- anomaly_alert, output, 1, equals |alert_reg.
- alert_code, output, 8, equals alert_reg.
- dmem_err, output, 1, registered one-cycle pulse flagging an unmapped access.

Behaviour:
- Address map (word index w = dmem_addr[31:2]):
  - RAM: dmem_addr[31:28] = 0 and w < RAM_WORDS.
  - 0x1000_0000 SENSOR_DATA (read pops).
  - 0x1000_0004 STATUS (read only).
  - 0x1000_0008 ALERT (read/write).
  - 0x1000_000C OVF (read; any write clears).
  - Everything else is unmapped.
- Reads are combinational:
  - dmem_rdata is driven whenever dmem_en = 1 and dmem_we = 0; otherwise it is 0.
  - Unmapped reads return 0.
- RAM:
  - Store writes mem[w] at the clock edge.
  - RAM contents are not reset.
  - A load in the cycle after a store to the same word returns the new data. There is no same-cycle read/write conflict, because the interface carries one access per cycle.
- SENSOR_DATA read:
  - Returns the FIFO head; the pop happens at the edge.
  - Reading when empty returns 0 with no pointer change and no error.
  - Stores to SENSOR_DATA and STATUS are ignored, with no error.
- STATUS read value: {ovf[15:0], count[7:0], 6'b0, full, empty}. ovf is zero-extended or truncated to 16 bits; count is zero-extended to 8 bits.
- FIFO:
  - Circular buffer with read/write pointers and a count from 0 to FIFO_DEPTH.
  - Push when sensor_valid && sensor_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - sensor_ready = (count != FIFO_DEPTH). A push is never accepted while full, even if a pop occurs in the same cycle.
- Overflow:
  - sensor_valid && !sensor_ready increments ovf, which saturates at 2^OVF_W-1.
  - The offered sample is dropped.
  - A clear (OVF write) and an overflow event in the same cycle leave ovf = 1.
  - An OVF read returns {zeros, ovf}.
- ALERT:
  - Store sets alert_reg <= dmem_wdata[7:0].
  - Read returns {24'b0, alert_reg}.
  - anomaly_alert and alert_code follow alert_reg from the cycle after the write.
- dmem_err: asserted for exactly one cycle, in the cycle after any dmem_en = 1 access to an unmapped address (load or store); otherwise 0. Unmapped stores change no state.
- Reset (rst_n = 0 at an edge), which has priority over every other event in that cycle:
  - Pointers, count, ovf, alert_reg and dmem_err are cleared.
  - Resulting outputs: sensor_ready = 1, anomaly_alert = 0, alert_code = 0, dmem_err = 0.
  - A push or pop coincident with reset is discarded.
- dmem_en = 0: no state change from the bus side; the sensor side keeps operating.

Test Plan:
1. RAM round trip: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 (and 0x0000_0013) -> dmem_rdata = 0xDEADBEEF both times; dmem_err stays 0.
2. FIFO order and wrap: push 0x11..0x18 (FIFO_DEPTH = 8) -> sensor_ready = 0 and STATUS = 0x0000_0802. Then pop 3, push 0x19..0x1B, and pop all -> reads in order 0x11..0x1B; STATUS = 0x0000_0001.
3. Overflow: with the FIFO full, hold sensor_valid for 5 cycles -> OVF = 5 and FIFO contents unchanged. Write OVF in a cycle with an overflow event -> OVF = 1. Drive 70000 more overflow events -> OVF = 0xFFFF.
4. Concurrent push and pop at count = 4 for 10 cycles -> count stays 4 and popped data matches push order delayed by 4.
5. Alert and errors: store 0x0000_00A5 to ALERT -> the next cycle shows alert_code = 0xA5 and anomaly_alert = 1. A load from 0x2000_0000 -> dmem_rdata = 0 and dmem_err high for exactly 1 cycle. A store to 0x0000_1000 (RAM_WORDS = 1024) -> dmem_err pulse and RAM unchanged.
6. Reset mid-operation: with count = 5, ovf = 3 and alert = 0x01, hold rst_n low for one edge while pushing and popping -> count = 0, STATUS = 0x0000_0001, anomaly_alert = 0, sensor_ready = 1; RAM data is retained.
